// File: rtl/matmul_sequencer.sv
// matmul_sequencer: step sequencer for C(2x3) = A(2x3) * B(3x3).
// Drives an external mod-18 step counter, decodes each step into A/B operand
// addresses and MAC control, and delays the write strobe by MAC_LAT cycles.
// Optional range check on the counter value: define MATMUL_SEQ_ERRCHK_EN.
module matmul_sequencer #(
    parameter int MAC_LAT = 1
) (
    input  logic       clk,
    input  logic       mr,
    input  logic       start,
    input  logic       hold,
    input  logic [4:0] count,
    output logic       cnt_ce,
    output logic       cnt_mr,
    output logic       op_valid,
    output logic [2:0] a_addr,
    output logic [3:0] b_addr,
    output logic       acc_clr,
    output logic       c_wr,
    output logic [2:0] c_addr,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] drain_cnt;
    logic       row;
    logic [3:0] rem;
    logic [1:0] col;
    logic [1:0] kk;
    logic [2:0] c_idx;
    logic       step_ok;
    logic       wr_in;
    logic [2:0] addr_in;
    logic       wr_pipe   [MAC_LAT];
    logic [2:0] addr_pipe [MAC_LAT];

`ifdef MATMUL_SEQ_ERRCHK_EN
    logic       bad_count;
    assign bad_count = (count > 5'd17);
`endif

    // Split the step number into row i, column j and inner index k
    always_comb begin
        row = (count >= 5'd9);
        rem = row ? 4'(count - 5'd9) : count[3:0];
        if (rem >= 4'd6) begin
            col = 2'd2;
            kk  = 2'(rem - 4'd6);
        end else if (rem >= 4'd3) begin
            col = 2'd1;
            kk  = 2'(rem - 4'd3);
        end else begin
            col = 2'd0;
            kk  = rem[1:0];
        end
        c_idx = (row ? 3'd3 : 3'd0) + {1'b0, col};
    end

    // Next-state and output decode for the sequencer FSM
    always_comb begin
        state_next = state;
        cnt_ce     = 1'b0;
        cnt_mr     = 1'b1;
        op_valid   = 1'b0;
        a_addr     = 3'd0;
        b_addr     = 4'd0;
        acc_clr    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        step_ok    = !hold;
`ifdef MATMUL_SEQ_ERRCHK_EN
        step_ok    = !hold && !bad_count;
`endif
        case (state)
            IDLE: begin
                cnt_mr = 1'b0;
                busy   = 1'b0;
                if (start) state_next = RUN;
            end
            RUN: begin
`ifdef MATMUL_SEQ_ERRCHK_EN
                if (bad_count) state_next = IDLE;
`endif
                if (step_ok) begin
                    cnt_ce   = 1'b1;
                    op_valid = 1'b1;
                    a_addr   = (row ? 3'd3 : 3'd0) + {1'b0, kk};
                    b_addr   = ({2'b00, kk} * 4'd3) + {2'b00, col};
                    acc_clr  = (kk == 2'd0);
                    if (count == 5'd17) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == 2'(MAC_LAT - 1)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!mr) state <= IDLE;
        else     state <= state_next;
    end

    // Count cycles spent in DRAIN so the last MAC result can land
    always_ff @(posedge clk) begin
        if (!mr || state != DRAIN) drain_cnt <= 2'd0;
        else                       drain_cnt <= drain_cnt + 2'd1;
    end

    assign wr_in   = op_valid && (kk == 2'd2);
    assign addr_in = wr_in ? c_idx : 3'd0;

    // Result write delay line; keeps moving through memory stalls
    always_ff @(posedge clk) begin
        if (!mr) begin
            for (int s = 0; s < MAC_LAT; s++) begin
                wr_pipe[s]   <= 1'b0;
                addr_pipe[s] <= 3'd0;
            end
        end else begin
            wr_pipe[0]   <= wr_in;
            addr_pipe[0] <= addr_in;
            for (int s = 1; s < MAC_LAT; s++) begin
                wr_pipe[s]   <= wr_pipe[s-1];
                addr_pipe[s] <= addr_pipe[s-1];
            end
        end
    end

    assign c_wr   = wr_pipe[MAC_LAT-1];
    assign c_addr = addr_pipe[MAC_LAT-1];

`ifdef MATMUL_SEQ_ERRCHK_EN
    // Sticky flag for an out-of-range counter value seen while running
    always_ff @(posedge clk) begin
        if (!mr)                          err <= 1'b0;
        else if (state == IDLE && start)  err <= 1'b0;
        else if (state == RUN && bad_count) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Testbench for matmul_sequencer: runs MAC_LAT=1 and MAC_LAT=3 instances side
// by side, each with its own falling-edge step counter model.
module tb_matmul_sequencer;

   logic       clk = 1'b0;
   logic       mr;
   logic       hold;
   logic       forceOn;
   logic       startS   [2];
   logic [4:0] countS   [2];
   logic [4:0] cntReg   [2] = '{5'd0, 5'd0};
   logic       ceQ      [2];
   logic       mrQ      [2];
   logic       cntCe    [2];
   logic       cntMr    [2];
   logic       opValid  [2];
   logic [2:0] aAddr    [2];
   logic [3:0] bAddr    [2];
   logic       accClr   [2];
   logic       cWr      [2];
   logic [2:0] cAddr    [2];
   logic       busy     [2];
   logic       done     [2];
   logic       err      [2];

   int checkCount = 0;
   int errorCount = 0;
   int LAT [2] = '{1, 3};
   int aTab [18] = '{0,1,2,0,1,2,0,1,2,3,4,5,3,4,5,3,4,5};
   int bTab [18] = '{0,3,6,1,4,7,2,5,8,0,3,6,1,4,7,2,5,8};
   int opN [2];
   int wrN [2];
   int doneN [2];
   int doneT [2];
   int busyN [2];
   int firstWrT [2];
   int lastWrT [2];

   matmul_sequencer #(.MAC_LAT(1)) dut1 (
      .clk(clk), .mr(mr), .start(startS[0]), .hold(hold), .count(countS[0]),
      .cnt_ce(cntCe[0]), .cnt_mr(cntMr[0]), .op_valid(opValid[0]),
      .a_addr(aAddr[0]), .b_addr(bAddr[0]), .acc_clr(accClr[0]),
      .c_wr(cWr[0]), .c_addr(cAddr[0]), .busy(busy[0]), .done(done[0]),
      .err(err[0])
   );

   matmul_sequencer #(.MAC_LAT(3)) dut3 (
      .clk(clk), .mr(mr), .start(startS[1]), .hold(hold), .count(countS[1]),
      .cnt_ce(cntCe[1]), .cnt_mr(cntMr[1]), .op_valid(opValid[1]),
      .a_addr(aAddr[1]), .b_addr(bAddr[1]), .acc_clr(accClr[1]),
      .c_wr(cWr[1]), .c_addr(cAddr[1]), .busy(busy[1]), .done(done[1]),
      .err(err[1])
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Counter control is captured on the rising edge
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         ceQ[i] <= cntCe[i];
         mrQ[i] <= cntMr[i];
      end
   end

   // Mod-18 step counter advancing on the falling edge
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!mrQ[i])     cntReg[i] <= 5'd0;
         else if (ceQ[i]) cntReg[i] <= (cntReg[i] == 5'd17) ? 5'd0 : cntReg[i] + 5'd1;
      end
   end

   // Optional override used to inject an illegal counter value
   always_comb begin
      for (int i = 0; i < 2; i++) countS[i] = forceOn ? 5'd20 : cntReg[i];
   end

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Checks every output except cnt_mr is low, for the cycle after an mr pulse
   task automatic checkQuiet(input string tag, input int i);
      checkOutput(tag, int'({cntCe[i], cntMr[i], opValid[i], accClr[i], cWr[i],
                             busy[i], done[i], err[i]}), 0);
      checkOutput({tag, "_addr"}, int'(aAddr[i]) + int'(bAddr[i]) + int'(cAddr[i]), 0);
   endtask

   // One transaction: start at t=0, optional hold window, mr pulse, extra starts
   task automatic applyStimulus(input int holdFrom, input int holdLen, input int mrAt,
                                input int midPulseAt, input bit donePulse, input int nCycles);
      for (int i = 0; i < 2; i++) begin
         opN[i] = 0; wrN[i] = 0; doneN[i] = 0; doneT[i] = -1;
         busyN[i] = 0; firstWrT[i] = -1; lastWrT[i] = -1;
      end
      for (int t = 0; t < nCycles; t++) begin
         @(negedge clk);
         mr   = (t == mrAt) ? 1'b0 : 1'b1;
         hold = (t >= holdFrom) && (t < holdFrom + holdLen);
         for (int i = 0; i < 2; i++)
            startS[i] = (t == 0) || (t == midPulseAt) ||
                        (donePulse && t == 19 + LAT[i] + holdLen);
         #2;
         for (int i = 0; i < 2; i++) begin
            string pre;
            pre = $sformatf("L%0d t%0d", LAT[i], t);
            if (opValid[i]) begin
               if (opN[i] < 18) begin
                  checkOutput({pre, " a_addr"}, int'(aAddr[i]), aTab[opN[i]]);
                  checkOutput({pre, " b_addr"}, int'(bAddr[i]), bTab[opN[i]]);
                  checkOutput({pre, " acc_clr"}, int'(accClr[i]), int'(opN[i] % 3 == 0));
               end else begin
                  checkOutput({pre, " extra_op"}, opN[i], 17);
               end
               opN[i]++;
            end else begin
               checkOutput({pre, " addr_idle"}, int'(aAddr[i]) + int'(bAddr[i]), 0);
            end
            if (hold) checkOutput({pre, " op_in_hold"}, int'(opValid[i]), 0);
            if (holdLen > 0 && t >= holdFrom && t <= holdFrom + holdLen)
               checkOutput({pre, " count_held"}, int'(countS[i]), holdFrom - 1);
            if (cWr[i]) begin
               checkOutput({pre, " c_addr"}, int'(cAddr[i]), wrN[i]);
               if (wrN[i] == 0) firstWrT[i] = t;
               lastWrT[i] = t;
               wrN[i]++;
            end
            if (done[i]) begin
               doneN[i]++;
               doneT[i] = t;
            end
            if (busy[i]) busyN[i]++;
            if (t == mrAt + 1) checkQuiet({pre, " after_mr"}, i);
            if (t == mrAt + 2) checkOutput({pre, " count_cleared"}, int'(countS[i]), 0);
         end
      end
      @(negedge clk);
      mr = 1'b1; hold = 1'b0;
      for (int i = 0; i < 2; i++) startS[i] = 1'b0;
   endtask

   // Summary checks for an undisturbed run delayed by holdLen stalled cycles
   task automatic checkFullRun(input string tag, input int holdLen);
      for (int i = 0; i < 2; i++) begin
         string pre;
         pre = $sformatf("%s L%0d", tag, LAT[i]);
         checkOutput({pre, " ops"}, opN[i], 18);
         checkOutput({pre, " writes"}, wrN[i], 6);
         checkOutput({pre, " first_wr_t"}, firstWrT[i], 3 + LAT[i]);
         checkOutput({pre, " last_wr_t"}, lastWrT[i], 18 + LAT[i] + holdLen);
         checkOutput({pre, " done_n"}, doneN[i], 1);
         checkOutput({pre, " done_t"}, doneT[i], 19 + LAT[i] + holdLen);
         checkOutput({pre, " busy_n"}, busyN[i], 19 + LAT[i] + holdLen);
      end
   endtask

   initial begin
      mr = 1'b0; hold = 1'b0; forceOn = 1'b0;
      startS[0] = 1'b0; startS[1] = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
         checkQuiet($sformatf("L%0d reset", LAT[i]), i);
         checkOutput($sformatf("L%0d reset_count", LAT[i]), int'(countS[i]), 0);
      end
      @(negedge clk);
      mr = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] plain run");
      applyStimulus(-1, 0, -1, -1, 1'b0, 30);
      checkFullRun("plain", 0);

      $display("[TB] hold for three cycles at count 4");
      applyStimulus(5, 3, -1, -1, 1'b0, 32);
      checkFullRun("hold", 3);

      $display("[TB] mr pulse at count 10");
      applyStimulus(-1, 0, 11, -1, 1'b0, 30);
      for (int i = 0; i < 2; i++) begin
         string pre;
         pre = $sformatf("mr L%0d", LAT[i]);
         checkOutput({pre, " ops"}, opN[i], 11);
         checkOutput({pre, " writes"}, wrN[i], (LAT[i] == 1) ? 3 : 2);
         checkOutput({pre, " done_n"}, doneN[i], 0);
         checkOutput({pre, " busy_n"}, busyN[i], 11);
      end

      $display("[TB] restart after mr");
      applyStimulus(-1, 0, -1, -1, 1'b0, 30);
      checkFullRun("restart", 0);

      $display("[TB] start pulses during RUN and DONE");
      applyStimulus(-1, 0, -1, 5, 1'b1, 40);
      checkFullRun("ignored_start", 0);

`ifdef MATMUL_SEQ_ERRCHK_EN
      $display("[TB] illegal count injection");
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         forceOn = (t == 5);
         startS[0] = (t == 0) || (t == 9);
         startS[1] = (t == 0) || (t == 9);
         #2;
         for (int i = 0; i < 2; i++) begin
            string pre;
            pre = $sformatf("errchk L%0d t%0d", LAT[i], t);
            if (t == 5) checkOutput({pre, " op_ce"}, int'(opValid[i]) + int'(cntCe[i]), 0);
            if (t == 6 || t == 9) begin
               checkOutput({pre, " err"}, int'(err[i]), 1);
               checkOutput({pre, " busy"}, int'(busy[i]), 0);
            end
            if (t == 10) begin
               checkOutput({pre, " err"}, int'(err[i]), 0);
               checkOutput({pre, " busy"}, int'(busy[i]), 1);
            end
            checkOutput({pre, " done"}, int'(done[i]), 0);
         end
      end
      @(negedge clk);
      forceOn = 1'b0; startS[0] = 1'b0; startS[1] = 1'b0; mr = 1'b0;
      repeat (2) @(negedge clk);
      mr = 1'b1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Control sequencer for the matrix-multiply datapath: C(2×3) = A(2×3) · B(3×3), 18 MAC steps. Drives the clock-enable and reset of the downstream 5-bit mod-18 step counter and consumes its `count` output. Decodes each step into operand/result addresses and MAC control, with start/busy/done handshake and memory-stall support.

## Interface
- `MAC_LAT`, default 1: cycles from an operand issue to the matching accumulator result; legal range 1–4.
- `clk`  in  1  system clock; all state updates on rising edge.
- `mr`  in  1  reset, synchronous, active-low.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `hold`  in  1  operand-memory stall; freezes step advance in RUN.
- `count`  in  5  step counter value (0..17), `count = i*9 + j*3 + k`.
- `cnt_ce`  out  1  counter clock-enable.
- `cnt_mr`  out  1  counter reset, active-low; holds counter at 0.
- `op_valid`  out  1  operands at `a_addr`/`b_addr` valid this cycle.
- `a_addr`  out  3  A index, `i*3+k`.
- `b_addr`  out  4  B index, `k*3+j`.
- `acc_clr`  out  1  clear accumulator (first k of an element).
- `c_wr`  out  1  write accumulator to C.
- `c_addr`  out  3  C index, `i*3+j`.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky illegal-count flag; cleared only by `mr` or an accepted `start`.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `cnt_mr`=0, `cnt_ce`=0. `start`=1 → RUN.
- RUN: `cnt_mr`=1, `cnt_ce`=`op_valid`=!`hold`. Decode from `count`: i = (count≥9), r = count−9i, j = r/3, k = r mod 3. `acc_clr` = `op_valid` & (k==0). When `count`==17 and !`hold` → DRAIN; the counter wraps to 0 on that step.
- DRAIN: stays exactly MAC_LAT cycles; `cnt_ce`=0, `op_valid`=0 → DONE.
- DONE: `done`=1 for one cycle → IDLE. `start` in DONE is ignored.
- Result path: `c_wr` = (`op_valid` & k==2) delayed MAC_LAT cycles. `c_addr` is delayed identically. The delay line always advances and ignores `hold`.
- All address outputs are 0 when `op_valid`=0.
- `start` while `busy` is ignored. `hold` outside RUN is ignored.
- `mr`=0 at any edge: state → IDLE, delay line flushed, and on the next cycle all outputs = 0 except `cnt_mr`=0. An in-flight `c_wr` is discarded.

## Timing
- Counter updates on the falling edge of `clk`. A step enabled at rising edge t is visible on `count` at edge t+1, giving one step per non-held RUN cycle.
- `start` sampled at t0 → RUN at t1 with `count`=0. With no `hold`, steps run t1..t18.
- DRAIN runs t19..t18+MAC_LAT. `done` fires at t19+MAC_LAT.
- `busy` is high t1 through the `done` cycle inclusive.
- Six `c_wr` pulses occur at t3+MAC_LAT, t6+MAC_LAT, …, t18+MAC_LAT.
- Each held RUN cycle extends the op sequence and all later events by one cycle.

## Configuration
- `MATMUL_SEQ_ERRCHK_EN` defined: in RUN, `count`>17 sets `err`, drops `op_valid`/`cnt_ce`, and forces IDLE next cycle, with no `done`. The delay line still drains.
- Undefined: no range check. `err` is tied 0. Decode of illegal counts is unspecified.

## Test plan
- MAC_LAT=1, no hold, `start` at t0:
  - 18 `op_valid` cycles with (a,b) = (0,0),(1,3),(2,6),(0,1)….
  - `c_wr` with `c_addr` 0..5 at t4,t7,…,t19.
  - `done` at t20; `busy` t1..t20.
- `hold`=1 for 3 cycles at `count`=4: `count` stays at 4, `op_valid`=0 during hold, `done` at t23, `c_addr` sequence unchanged.
- MAC_LAT=3: last `c_wr` at t21, DRAIN for 3 cycles, `done` at t22.
- `mr`=0 at `count`=10: next cycle IDLE, `cnt_mr`=0, `count` returns to 0, no further `c_wr`, no `done`. A new `start` then completes normally.
- `start` pulsed during RUN and during DONE: ignored, exactly one `done` produced.
- `MATMUL_SEQ_ERRCHK_EN` defined, `count` forced to 20 in RUN: `err`=1 next cycle, state IDLE, no `done`. A following `start` clears `err`.
